// File: rtl/resize_hls_axis_divsu.sv
`default_nettype none
// ============================================================================
// Module  : resize_hls_axis_divsu
// Brief   : Sequential signed-by-unsigned restoring divider, one quotient bit
//           per cycle. Produces a saturated quotient and a signed remainder.
// Revision: 1.0 - initial release
// ============================================================================
module resize_hls_axis_divsu #(
  parameter int DIVIDEND_WIDTH = 28,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int QUOT_WIDTH     = 20
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOT_WIDTH-1:0]     quotient,
  output logic [DIVISOR_WIDTH:0]    remainder,
  output logic                      ovf,
  output logic                      dz
);

  localparam int W = DIVIDEND_WIDTH;
  localparam int D = DIVISOR_WIDTH;
  localparam int Q = QUOT_WIDTH;
  localparam int c_cnt_w = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(W - 1);

  typedef logic signed [W:0] wide_t;
  localparam longint c_qmax_l = (64'sd1 <<< (Q - 1)) - 64'sd1;
  localparam wide_t  c_qmax_ext = wide_t'(c_qmax_l);
  localparam wide_t  c_qmin_ext = wide_t'(-c_qmax_l - 64'sd1);
  localparam logic [Q-1:0] c_qmax = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0] c_qmin = {1'b1, {(Q-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_cnt_w-1:0]  r_cnt;
  logic [W-1:0]        r_num;
  logic [D-1:0]        r_rem;
  logic [D-1:0]        r_div;
  logic                r_neg;
  logic                r_dz;
  logic                r_phase;
  logic signed [W:0]   r_qs;
  logic signed [D:0]   r_rs;
  logic [Q-1:0]        r_quot;
  logic [D:0]          r_remo;
  logic                r_ovf;
  logic                r_dzo;

  logic [W-1:0]        w_abs;
  logic [D:0]          w_shift;
  logic [D-1:0]        w_diff;
  logic                w_ge;
  logic signed [W:0]   w_qmag;
  logic signed [D:0]   w_rmag;

  // Magnitude of the most negative dividend still fits the unsigned register
  assign w_abs   = dividend[W-1] ? (~dividend + 1'b1) : dividend;
  assign w_shift = {r_rem, r_num[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[D-1:0] - r_div;
  assign w_qmag  = {1'b0, r_num};
  assign w_rmag  = {1'b0, r_rem};

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) r_state <= IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = BUSY;
      end
      BUSY: if (r_cnt == c_last) w_next = SIGN;
      SIGN: if (r_phase) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_cnt   <= '0;
      r_num   <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg   <= 1'b0;
      r_dz    <= 1'b0;
      r_phase <= 1'b0;
      r_qs    <= '0;
      r_rs    <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_ovf   <= 1'b0;
      r_dzo   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_num   <= w_abs;
            r_neg   <= dividend[W-1];
            r_div   <= divisor;
            r_dz    <= (divisor == '0);
            r_rem   <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
          end
        end
        BUSY: begin
          // Quotient bits shift into the numerator register as it empties
          r_num <= {r_num[W-2:0], w_ge};
          r_rem <= w_ge ? w_diff : w_shift[D-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        SIGN: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            r_qs    <= r_neg ? -w_qmag : w_qmag;
            r_rs    <= r_neg ? -w_rmag : w_rmag;
          end else begin
            r_phase <= 1'b0;
            r_dzo   <= r_dz;
            if (r_dz) begin
              r_quot <= r_neg ? c_qmin : c_qmax;
              r_remo <= '0;
              r_ovf  <= 1'b0;
            end else begin
              r_remo <= r_rs;
              if (r_qs > c_qmax_ext) begin
                r_quot <= c_qmax;
                r_ovf  <= 1'b1;
              end else if (r_qs < c_qmin_ext) begin
                r_quot <= c_qmin;
                r_ovf  <= 1'b1;
              end else begin
                r_quot <= r_qs[Q-1:0];
                r_ovf  <= 1'b0;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign ovf       = r_ovf;
  assign dz        = r_dzo;

endmodule
`default_nettype wire

// File: tb/tb_resize_hls_axis_divsu.sv
`default_nettype none
// Randomized self-checking bench for resize_hls_axis_divsu against an
// arithmetic reference model (truncating division with saturation).
module tb_resize_hls_axis_divsu;
  localparam int W = 28;
  localparam int D = 8;
  localparam int Q = 20;

  logic          ap_clk    = 1'b0;
  logic          ap_rst_n  = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dividend  = '0;
  logic [D-1:0]  divisor   = '0;
  logic          in_ready;
  logic          out_valid;
  logic [Q-1:0]  quotient;
  logic [D:0]    remainder;
  logic          ovf;
  logic          dz;

  int n_tests = 0;
  int n_fail  = 0;

  resize_hls_axis_divsu #(
    .DIVIDEND_WIDTH(W),
    .DIVISOR_WIDTH (D),
    .QUOT_WIDTH    (Q)
  ) u_dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dividend (dividend),
    .divisor  (divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient (quotient),
    .remainder(remainder),
    .ovf      (ovf),
    .dz       (dz)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model(input longint a, input longint b,
                       output longint q, output longint r,
                       output longint e_ovf, output longint e_dz);
    longint qmax;
    longint qmin;
    qmax = (64'sd1 <<< (Q - 1)) - 1;
    qmin = -(64'sd1 <<< (Q - 1));
    e_ovf = 0;
    if (b == 0) begin
      q = (a < 0) ? qmin : qmax;
      r = 0;
      e_dz = 1;
    end else begin
      q = a / b;
      r = a % b;
      e_dz = 0;
      if (q > qmax) begin q = qmax; e_ovf = 1; end
      else if (q < qmin) begin q = qmin; e_ovf = 1; end
    end
  endtask

  task automatic do_op(input longint a, input longint b, input int hold, input string tag);
    longint eq, er, eo, ed;
    int guard;
    int lat;
    bit stable;
    logic [Q-1:0] q0;
    logic [D:0]   r0;
    logic         o0, z0;
    model(a, b, eq, er, eo, ed);
    dividend = W'(a);
    divisor  = D'(b);
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge ap_clk); #1; guard++;
    end
    check({tag, "/accept_wait"}, guard, 0);
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    dividend = W'($urandom);
    divisor  = D'($urandom);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge ap_clk); #1; lat++;
    end
    check({tag, "/latency"}, lat, W + 2);
    check({tag, "/quotient"}, longint'($signed(quotient)), eq);
    check({tag, "/remainder"}, longint'($signed(remainder)), er);
    check({tag, "/ovf"}, longint'(ovf), eo);
    check({tag, "/dz"}, longint'(dz), ed);
    if (hold > 0) begin
      q0 = quotient; r0 = remainder; o0 = ovf; z0 = dz;
      in_valid = 1'b1;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        dividend = W'($urandom);
        divisor  = D'($urandom);
        @(posedge ap_clk); #1;
        if (!out_valid || in_ready || quotient !== q0 || remainder !== r0 ||
            ovf !== o0 || dz !== z0)
          stable = 1'b0;
      end
      check({tag, "/hold_stable"}, longint'(stable), 1);
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    out_ready = 1'b0;
    check({tag, "/post_hs_valid"}, longint'(out_valid), 0);
    check({tag, "/post_hs_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    logic [W-1:0] tmp;
    longint a, b, qq, rr;
    int kind, bad;

    ap_rst_n = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst/in_ready", longint'(in_ready), 1);
    check("rst/out_valid", longint'(out_valid), 0);
    check("rst/quotient", longint'(quotient), 0);
    check("rst/remainder", longint'(remainder), 0);
    check("rst/ovf_dz", longint'({ovf, dz}), 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;

    do_op(1000, 7, 0, "pos");
    do_op(-1000, 7, 0, "neg");
    do_op(-60000000, 200, 0, "roundtrip");
    do_op(134217727, 1, 0, "sat_pos");
    do_op(-134217728, 255, 0, "sat_neg");
    do_op(-5, 0, 10, "dz_bp");
    do_op(0, 0, 0, "dz_zero");
    do_op(134217727, 255, 2, "sat_pos255");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      tmp = W'($urandom);
      a = longint'($signed(tmp));
      b = longint'($urandom_range(1, 255));
      if (kind == 1) b = 0;
      if (kind == 2) begin
        qq = longint'($urandom_range(0, 600000)) - 300000;
        rr = longint'($urandom_range(0, 254)) % b;
        a = qq * b + ((qq < 0) ? -rr : rr);
      end
      if (kind == 3) a = ($urandom_range(0, 1) == 1) ? -134217728 : 134217727;
      do_op(a, b, $urandom_range(0, 3), "rnd");
    end

    do_op(1000, 7, 0, "pre_rst");
    dividend = W'(5000000);
    divisor  = D'(3);
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    check("midrst/quotient", longint'(quotient), 0);
    check("midrst/remainder", longint'(remainder), 0);
    check("midrst/ovf_dz", longint'({ovf, dz}), 0);
    check("midrst/out_valid", longint'(out_valid), 0);
    check("midrst/in_ready", longint'(in_ready), 1);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge ap_clk); #1;
      if (out_valid) bad++;
    end
    check("midrst/no_result", bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/resize_hls_axis_divsu.md
# resize_hls_axis_divsu

Sequential signed-by-unsigned divider for the resize datapath. It is the inverse of the signed×unsigned weight multiply: it takes a signed accumulated product and an unsigned 8-bit weight and returns a signed truncated quotient and remainder. It normalises interpolation sums back to pixel scale and recovers scale ratios. One restoring-division bit is produced per cycle, behind valid/ready handshakes on both sides.

## Interface
- DIVIDEND_WIDTH, 28, signed dividend width (W)
- DIVISOR_WIDTH, 8, unsigned divisor width (D)
- QUOT_WIDTH, 20, signed quotient width (Q)
- ap_clk  in  1  clock, all state on rising edge
- ap_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  operand valid
- in_ready  out  1  divider can accept operands
- dividend  in  W  signed numerator
- divisor  in  D  unsigned denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  Q  signed quotient, truncated toward zero, saturated
- remainder  out  D+1  signed remainder, sign of dividend
- ovf  out  1  quotient saturated
- dz  out  1  divisor was zero

## Operation
- States: IDLE, BUSY, SIGN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready:
  - latch |dividend| into a W-bit unsigned register, plus the dividend sign bit, divisor, and dz=(divisor==0);
  - clear the partial remainder and bit counter;
  - go to BUSY.
- BUSY: one restoring step per cycle, MSB first:
  - shift {rem, num} left by one;
  - if rem ≥ divisor, subtract and set the quotient bit.
  - Runs exactly W cycles (counter 0..W-1), then goes to SIGN. The same W cycles run when dz=1; the result is discarded.
- SIGN: negate the quotient magnitude and remainder if the dividend was negative.
  - Saturate: if the magnitude exceeds 2^(Q-1)-1 (positive) or 2^(Q-1) (negative), drive 2^(Q-1)-1 or -2^(Q-1) and set ovf=1.
  - When saturated, the remainder is still the true signed remainder.
  - dz=1 forces quotient to saturated max with the dividend's sign (dividend 0 gives positive), remainder=0, ovf=0.
  - Go to DONE.
- DONE: out_valid=1 and the output registers are held stable. On out_ready, go to IDLE.
- in_ready is low in BUSY, SIGN and DONE. Operands are never accepted while a result is pending.
- Arithmetic width rules:
  - -2^(W-1) must be handled: its magnitude fits the W-bit unsigned register.
  - The remainder magnitude is < divisor ≤ 2^D-1, so D+1 signed bits suffice.

## Timing
- Reset (async assert, synchronous deassert handled upstream):
  - state=IDLE; in_ready=1; out_valid=0;
  - quotient, remainder, ovf, dz all 0.
- Reset asserted mid-BUSY/SIGN/DONE aborts the operation. No result is emitted after release.
- Latency is fixed for all operands, including dz: handshake on edge 0 gives out_valid=1 after edge W+2 (30 cycles at default).
- The output handshake at edge n gives in_ready=1 after edge n+1 (state IDLE).
- Minimum initiation interval: W+3 cycles.
- in_valid with in_ready=0 is ignored. Operands need not be held after acceptance.
- out_valid never drops without out_ready. Outputs do not change while out_valid=1.

## Test plan
- dividend=1000, divisor=7 -> quotient=142, remainder=6, ovf=0, dz=0; out_valid exactly 30 cycles after the accept edge.
- dividend=-1000, divisor=7 -> quotient=-142, remainder=-6.
- Round trip with the weight multiplier: dividend=-60000000 (-300000×200), divisor=200 -> quotient=-300000, remainder=0.
- Saturation:
  - dividend=134217727, divisor=1 -> quotient=524287, ovf=1, remainder=0;
  - dividend=-134217728, divisor=255 -> quotient=-524288, ovf=1, remainder=-8.
- Divide by zero: dividend=-5, divisor=0 -> quotient=-524288, remainder=0, dz=1, ovf=0, latency still 30.
- Backpressure and reset:
  - hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, a second in_valid is ignored;
  - after the out handshake, the next operand is accepted one cycle later;
  - separately, pull ap_rst_n low at BUSY count 12 -> all outputs 0 immediately, no out_valid after release.
